// File: rtl/interval_timer_ctrl_if.sv
// Counter-side bus between interval_timer_ctrl and the shared hold/down/up/load counter.
// master = sequencer (drives command and load data), slave = counter (returns its value).
interface interval_timer_ctrl_if #(
  parameter int N = 16
);
  logic [1:0]   cnt_control;
  logic [N-1:0] cnt_d;
  logic [N-1:0] cnt_q;

  modport master (output cnt_control, output cnt_d, input cnt_q);
  modport slave  (input cnt_control, input cnt_d, output cnt_q);
endinterface

// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer: loads a period into an external counter, counts it down and flags expiry.
// Define INTERVAL_TIMER_RELOAD_EN to build in periodic auto-reload; without it the timer is one-shot.
module interval_timer_ctrl #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic                 periodic,
  input  logic [N-1:0]         period,
  interval_timer_ctrl_if.master cnt,
  output logic                 busy,
  output logic                 expired,
  output logic [7:0]           exp_count
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, EXPIRE} state_t;

  localparam logic [1:0]   CTRL_HOLD = 2'b00;
  localparam logic [1:0]   CTRL_DOWN = 2'b01;
  localparam logic [1:0]   CTRL_LOAD = 2'b11;
  localparam logic [N-1:0] CNT_ONE   = N'(1);

  state_t       state, state_next;
  logic [N-1:0] period_r;
  logic         accept;
  logic         reload;

  assign accept = (state == IDLE) && start && !stop && (period != '0);

`ifdef INTERVAL_TIMER_RELOAD_EN
  logic periodic_r;

  always_ff @(posedge clk) begin
    if (reset)       periodic_r <= 1'b0;
    else if (accept) periodic_r <= periodic;
  end

  assign reload = periodic_r;
`else
  logic unused_periodic;
  assign unused_periodic = periodic;
  assign reload          = 1'b0;
`endif

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      period_r  <= '0;
      exp_count <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        period_r  <= period;
        exp_count <= '0;
      end else if (state == EXPIRE && !stop && exp_count != 8'hFF) begin
        exp_count <= exp_count + 8'd1;
      end
    end
  end

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    state_next      = state;
    cnt.cnt_control = CTRL_HOLD;
    if (state != IDLE && stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:   if (accept) state_next = LOAD;
        LOAD: begin
          cnt.cnt_control = CTRL_LOAD;
          state_next      = COUNT;
        end
        COUNT: begin
          if (!pause) begin
            // Last down-step takes the counter to zero as we enter EXPIRE.
            cnt.cnt_control = CTRL_DOWN;
            if (cnt.cnt_q == CNT_ONE) state_next = EXPIRE;
          end
        end
        EXPIRE: state_next = reload ? LOAD : IDLE;
      endcase
    end
  end

  assign cnt.cnt_d = period_r;
  assign busy      = (state != IDLE);
  assign expired   = (state == EXPIRE);

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: behavioural counter, reference model scoreboard and timing scenarios.
module tb_interval_timer_ctrl;
  localparam int N = 16;
`ifdef INTERVAL_TIMER_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  localparam int S_IDLE = 0, S_LOAD = 1, S_CNT = 2, S_EXP = 3;

  typedef struct packed {
    logic [1:0]   ctrl;
    logic [N-1:0] d;
    logic         busy;
    logic         expired;
    logic [7:0]   ecnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start, stop, pause, periodic;
  logic [N-1:0] period;
  logic         busy, expired;
  logic [7:0]   exp_count;
  logic [N-1:0] cnt;

  interval_timer_ctrl_if #(.N(N)) cbus ();

  interval_timer_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .periodic  (periodic),
    .period    (period),
    .cnt       (cbus),
    .busy      (busy),
    .expired   (expired),
    .exp_count (exp_count)
  );

  always #5 clk = ~clk;

  // Shared hold/down/up/load counter, driven only by the DUT command.
  initial cnt = '0;
  always @(posedge clk) begin
    case (cbus.cnt_control)
      2'b01:   cnt <= cnt - 1'b1;
      2'b10:   cnt <= cnt + 1'b1;
      2'b11:   cnt <= cbus.cnt_d;
      default: ;
    endcase
  end
  assign cbus.cnt_q = cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_seen[$];
  exp_t sb_q[$];

  int           m_state = S_IDLE;
  logic [N-1:0] m_period = '0;
  logic         m_periodic = 1'b0;
  logic [7:0]   m_exp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc - start_cyc);
    end
  endtask

  // One clock cycle: predict outputs, compare, then advance the model on the edge.
  task automatic step();
    exp_t e;
    logic [N-1:0] q;
    logic s_reset, s_start, s_stop, s_pause, s_periodic;
    logic [N-1:0] s_period;
    #1;
    q = cbus.cnt_q;
    s_reset = reset; s_start = start; s_stop = stop; s_pause = pause;
    s_periodic = periodic; s_period = period;

    e.d       = m_period;
    e.busy    = (m_state != S_IDLE);
    e.expired = (m_state == S_EXP);
    e.ecnt    = m_exp;
    if (s_stop && m_state != S_IDLE)          e.ctrl = 2'b00;
    else if (m_state == S_LOAD)               e.ctrl = 2'b11;
    else if (m_state == S_CNT && !s_pause)    e.ctrl = 2'b01;
    else                                      e.ctrl = 2'b00;
    sb_q.push_back(e);

    e = sb_q.pop_front();
    check("cnt_control", 32'(cbus.cnt_control), 32'(e.ctrl));
    check("cnt_d",       32'(cbus.cnt_d),       32'(e.d));
    check("busy",        32'(busy),             32'(e.busy));
    check("expired",     32'(expired),          32'(e.expired));
    check("exp_count",   32'(exp_count),        32'(e.ecnt));
    if (expired === 1'b1) exp_seen.push_back(cyc - start_cyc);

    @(posedge clk);
    if (s_reset) begin
      m_state = S_IDLE; m_period = '0; m_periodic = 1'b0; m_exp = '0;
    end else if (s_stop && m_state != S_IDLE) begin
      m_state = S_IDLE;
    end else begin
      case (m_state)
        S_IDLE: if (s_start && !s_stop && s_period != '0) begin
          m_period = s_period; m_periodic = s_periodic; m_exp = '0; m_state = S_LOAD;
        end
        S_LOAD: m_state = S_CNT;
        S_CNT:  if (!s_pause && q == N'(1)) m_state = S_EXP;
        default: begin
          if (m_exp != 8'd255) m_exp = m_exp + 8'd1;
          m_state = (RELOAD && m_periodic) ? S_LOAD : S_IDLE;
        end
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic begin_run(input logic [N-1:0] p, input logic per);
    period = p; periodic = per; start = 1'b1;
    start_cyc = cyc;
    exp_seen.delete();
    step();
    start = 1'b0;
  endtask

  task automatic check_expiries(input string tag, input int want_n, input int c0, input int c1, input int c2);
    int want[3];
    want[0] = c0; want[1] = c1; want[2] = c2;
    check({tag, "_n"}, exp_seen.size(), want_n);
    for (int i = 0; i < want_n && i < 3; i++)
      if (i < exp_seen.size()) check({tag, "_cyc"}, exp_seen[i], want[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0; period = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    step();
    reset = 1'b0;
    check("rst_busy",  32'(busy), 0);
    check("rst_cnt_d", 32'(cbus.cnt_d), 0);

    // One-shot, P=5: expiry in cycle 7, idle from cycle 8.
    begin_run(16'd5, 1'b0);
    run(9);
    check_expiries("oneshot", 1, 7, 0, 0);
    check("oneshot_count", 32'(exp_count), 1);
    check("oneshot_busy",  32'(busy), 0);

    // Pause for cycles 3..5 of a P=4 run: counter frozen, expiry slips to cycle 9.
    begin_run(16'd4, 1'b0);
    run(2);
    pause = 1'b1;
    run(3);
    check("pause_cnt_q", 32'(cbus.cnt_q), 3);
    pause = 1'b0;
    run(6);
    check_expiries("pause", 1, 9, 0, 0);

    // Stop in cycle 5 of P=10: idle in cycle 6, no expiry.
    begin_run(16'd10, 1'b0);
    run(4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 0);
    run(3);
    check_expiries("stop", 0, 0, 0, 0);
    check("stop_count", 32'(exp_count), 0);

    // Start while busy with a new period is ignored.
    begin_run(16'd10, 1'b0);
    step();
    period = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_cnt_d", 32'(cbus.cnt_d), 10);
    run(12);
    check_expiries("busy_start", 1, 12, 0, 0);

    // Zero period is ignored; P=1 expires in cycle 3.
    begin_run(16'd0, 1'b0);
    check("zero_busy", 32'(busy), 0);
    run(3);
    check_expiries("zero", 0, 0, 0, 0);
    begin_run(16'd1, 1'b0);
    run(4);
    check_expiries("p1", 1, 3, 0, 0);

    // Periodic request, P=3, stop in cycle 17.
    begin_run(16'd3, 1'b1);
    run(16);
    stop = 1'b1;
    step();
    stop = 1'b0;
    run(2);
    if (RELOAD) begin
      check_expiries("periodic", 3, 5, 10, 15);
      check("periodic_count", 32'(exp_count), 3);
    end else begin
      check_expiries("periodic", 1, 5, 0, 0);
      check("periodic_count", 32'(exp_count), 1);
    end
    check("periodic_busy", 32'(busy), 0);

`ifdef INTERVAL_TIMER_RELOAD_EN
    // 300 periodic expiries of P=1 saturate the count at 255.
    begin_run(16'd1, 1'b1);
    run(902);
    check("sat_n", exp_seen.size(), 300);
    check("sat_count", 32'(exp_count), 255);
    stop = 1'b1;
    step();
    stop = 1'b0;
    run(2);
`endif

    // Reset in cycle 4 of a P=8 run: counter keeps its value (6 -> 5 on that edge, then holds).
    begin_run(16'd8, 1'b0);
    run(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_busy",    32'(busy), 0);
    check("mid_rst_expired", 32'(expired), 0);
    check("mid_rst_cnt_d",   32'(cbus.cnt_d), 0);
    check("mid_rst_ctrl",    32'(cbus.cnt_control), 0);
    check("mid_rst_count",   32'(exp_count), 0);
    check("mid_rst_cnt_q",   32'(cbus.cnt_q), 5);
    step();
    check("mid_rst_cnt_q_hold", 32'(cbus.cnt_q), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
